// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Merges ALU and long-latency results onto one registered write port
//            and tracks which registers still await a long-latency write.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_rd,
    input  logic [31:0]             alu_data,
    output logic                    alu_stall,
    input  logic                    ll_valid,
    output logic                    ll_ready,
    input  logic [4:0]              ll_rd,
    input  logic [31:0]             ll_data,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [4:0]              query_rs1,
    input  logic [4:0]              query_rs2,
    output logic                    rs1_pending,
    output logic                    rs2_pending,
    output logic                    reg_write_enable,
    output logic [4:0]              rd,
    output logic [31:0]             write_data,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_STV_W-1:0] c_LIMIT = c_STV_W'(STARVE_LIMIT);

    logic [4:0]          r_mem_rd   [DEPTH];
    logic [31:0]         r_mem_data [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_STV_W-1:0]  r_starve;
    logic [31:0]         r_pending;
    logic                r_we;
    logic [4:0]          r_rd;
    logic [31:0]         r_data;

    logic                w_ll_ready;
    logic                w_push;
    logic                w_alu_cand;
    logic                w_fifo_cand;
    logic                w_force;
    logic                w_pop;
    logic                w_alu_win;
    logic [4:0]          w_head_rd;
    logic [31:0]         w_head_data;
    logic [31:0]         w_pend_nxt;

    // Gating with reset keeps ll_ready low for the whole reset interval.
    assign w_ll_ready  = reset && (r_count < c_DEPTH);
    assign w_push      = ll_valid && w_ll_ready && (ll_rd != 5'd0);
    assign w_alu_cand  = alu_valid && (alu_rd != 5'd0);
    assign w_fifo_cand = (r_count != '0);
    assign w_force     = w_alu_cand && w_fifo_cand && (r_starve == c_LIMIT);
    assign w_pop       = w_fifo_cand && (!w_alu_cand || w_force);
    assign w_alu_win   = w_alu_cand && !w_force;
    assign w_head_rd   = r_mem_rd[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // A same-cycle issue re-arms the bit even if the old entry retires now.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 1; i < 32; i++) begin
            w_pend_nxt[i] = (r_pending[i] && !(w_pop && (w_head_rd == 5'(i))))
                          || (issue_valid && (issue_rd == 5'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= ll_rd;
            r_mem_data[r_wr_ptr] <= ll_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
            r_we      <= 1'b0;
            r_rd      <= 5'd0;
            r_data    <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop || !w_fifo_cand) begin
                r_starve <= '0;
            end else if (w_alu_win && (r_starve != c_LIMIT)) begin
                r_starve <= r_starve + c_STV_W'(1);
            end

            r_pending <= w_pend_nxt;

            if (w_alu_win) begin
                r_we   <= 1'b1;
                r_rd   <= alu_rd;
                r_data <= alu_data;
            end else if (w_pop) begin
                r_we   <= 1'b1;
                r_rd   <= w_head_rd;
                r_data <= w_head_data;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    assign alu_stall        = w_force;
    assign ll_ready         = w_ll_ready;
    assign rs1_pending      = r_pending[query_rs1];
    assign rs2_pending      = r_pending[query_rs2];
    assign reg_write_enable = r_we;
    assign rd               = r_rd;
    assign write_data       = r_data;
    assign fifo_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed and randomised stimulus for writeback_arbiter, checked
//            every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        reg_write_enable;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [36:0] m_q[$];
    logic [31:0] m_pend;
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_last_stall;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .reg_write_enable(reg_write_enable), .rd(rd), .write_data(write_data),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend       = '0;
        m_starve     = 0;
        m_we         = 1'b0;
        m_rd         = 5'd0;
        m_data       = 32'd0;
        m_last_stall = 1'b0;
    endtask

    // One clock edge of the arbiter, described as queue operations.
    task automatic model_step();
        logic        alu_c;
        logic        fifo_win;
        logic [36:0] e;
        int          n;
        if (!reset) return;
        n        = m_q.size();
        alu_c    = alu_valid && (alu_rd != 5'd0);
        fifo_win = (n > 0) && (!alu_c || (m_starve == STARVE_LIMIT));
        m_last_stall = fifo_win && alu_c;
        if (fifo_win) begin
            e        = m_q.pop_front();
            m_we     = 1'b1;
            m_rd     = e[36:32];
            m_data   = e[31:0];
            m_pend[e[36:32]] = 1'b0;
            m_starve = 0;
        end else if (alu_c) begin
            m_we     = 1'b1;
            m_rd     = alu_rd;
            m_data   = alu_data;
            m_starve = (n == 0) ? 0 : ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT);
        end else begin
            m_we     = 1'b0;
            m_starve = 0;
        end
        if (ll_valid && (n < DEPTH) && (ll_rd != 5'd0)) m_q.push_back({ll_rd, ll_data});
        if (issue_valid && (issue_rd != 5'd0)) m_pend[issue_rd] = 1'b1;
    endtask

    always @(negedge clk) begin
        logic alu_c;
        alu_c = alu_valid && (alu_rd != 5'd0);
        chk("reg_write_enable", {31'd0, reg_write_enable}, {31'd0, m_we});
        chk("rd", {27'd0, rd}, {27'd0, m_rd});
        chk("write_data", write_data, m_data);
        chk("fifo_count", {30'd0, fifo_count}, m_q.size());
        chk("ll_ready", {31'd0, ll_ready}, {31'd0, reset && (m_q.size() < DEPTH)});
        chk("alu_stall", {31'd0, alu_stall},
            {31'd0, alu_c && (m_q.size() > 0) && (m_starve == STARVE_LIMIT)});
        chk("rs1_pending", {31'd0, rs1_pending}, {31'd0, (query_rs1 != 5'd0) && m_pend[query_rs1]});
        chk("rs2_pending", {31'd0, rs2_pending}, {31'd0, (query_rs2 != 5'd0) && m_pend[query_rs2]});
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        ll_valid    = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; query_rs1 = 5'd0; query_rs2 = 5'd0;
        model_reset();
        tick(); tick();
        chk("lit_reset_we", {31'd0, reg_write_enable}, 32'd0);
        chk("lit_reset_ready", {31'd0, ll_ready}, 32'd0);
        reset = 1'b1; #1;
        chk("lit_ready_after_release", {31'd0, ll_ready}, 32'd1);

        // ALU single write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; #1;
        chk("lit_alu_no_stall", {31'd0, alu_stall}, 32'd0);
        tick(); alu_valid = 1'b0;
        chk("lit_alu_we", {31'd0, reg_write_enable}, 32'd1);
        chk("lit_alu_rd", {27'd0, rd}, 32'd5);
        chk("lit_alu_data", write_data, 32'h1234);
        tick();
        chk("lit_idle_we", {31'd0, reg_write_enable}, 32'd0);
        chk("lit_idle_rd_hold", {27'd0, rd}, 32'd5);

        // Fill FIFO while ALU keeps the port busy, then drain
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hAAAA;
        tick();
        ll_rd = 5'd8; ll_data = 32'hBBBB;
        tick();
        ll_rd = 5'd20; ll_data = 32'h2020; #1;
        chk("lit_full_ready", {31'd0, ll_ready}, 32'd0);
        chk("lit_full_count", {30'd0, fifo_count}, 32'd2);
        tick();
        idle();
        tick();
        chk("lit_pop7_rd", {27'd0, rd}, 32'd7);
        chk("lit_pop7_data", write_data, 32'hAAAA);
        tick();
        chk("lit_pop8_rd", {27'd0, rd}, 32'd8);
        chk("lit_pop8_data", write_data, 32'hBBBB);
        chk("lit_drained_count", {30'd0, fifo_count}, 32'd0);

        // Starvation: ALU wins four times, then the FIFO head is forced
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3000;
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9999;
        tick();
        ll_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            alu_data = 32'h3000 + k;
            tick();
        end
        alu_data = 32'h3005; #1;
        chk("lit_starve_stall", {31'd0, alu_stall}, 32'd1);
        tick();
        chk("lit_forced_rd", {27'd0, rd}, 32'd9);
        chk("lit_forced_data", write_data, 32'h9999);
        tick();
        chk("lit_held_alu_rd", {27'd0, rd}, 32'd3);
        chk("lit_held_alu_data", write_data, 32'h3005);
        idle();

        // Scoreboard
        issue_valid = 1'b1; issue_rd = 5'd10; query_rs1 = 5'd10; query_rs2 = 5'd0;
        tick();
        issue_valid = 1'b0; #1;
        chk("lit_pend10_set", {31'd0, rs1_pending}, 32'd1);
        chk("lit_pend_x0", {31'd0, rs2_pending}, 32'd0);
        tick();
        ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA0A0;
        tick();
        ll_valid = 1'b0;
        chk("lit_pend10_queued", {31'd0, rs1_pending}, 32'd1);
        tick();
        chk("lit_pend10_clear", {31'd0, rs1_pending}, 32'd0);
        chk("lit_pop10_rd", {27'd0, rd}, 32'd10);
        issue_valid = 1'b1; issue_rd = 5'd11; query_rs1 = 5'd11;
        tick();
        issue_valid = 1'b0; ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'hB1B1;
        tick();
        ll_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd11;
        tick();
        issue_valid = 1'b0;
        chk("lit_set_wins", {31'd0, rs1_pending}, 32'd1);
        chk("lit_pop11_rd", {27'd0, rd}, 32'd11);

        // x0 destinations are dropped
        ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'hC0C0;
        tick();
        ll_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        tick();
        chk("lit_x0_alu_drop_rd", {27'd0, rd}, 32'd12);
        chk("lit_x0_alu_drop_data", write_data, 32'hC0C0);
        alu_valid = 1'b0; ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hBEEF;
        tick();
        ll_valid = 1'b0;
        chk("lit_ll_x0_count", {30'd0, fifo_count}, 32'd0);
        chk("lit_ll_x0_no_write", {31'd0, reg_write_enable}, 32'd0);

        // Reset mid-operation with a full FIFO and pending bits
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        ll_valid = 1'b1; ll_rd = 5'd13; ll_data = 32'hD13;
        tick();
        ll_rd = 5'd14; ll_data = 32'hD14;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd15;
        tick();
        issue_rd = 5'd16;
        tick();
        issue_valid = 1'b0; ll_valid = 1'b0; query_rs1 = 5'd15; query_rs2 = 5'd16; #1;
        chk("lit_pre_rst_pend15", {31'd0, rs1_pending}, 32'd1);
        chk("lit_pre_rst_count", {30'd0, fifo_count}, 32'd2);
        reset = 1'b0; model_reset(); #1;
        chk("lit_rst_we", {31'd0, reg_write_enable}, 32'd0);
        chk("lit_rst_rd", {27'd0, rd}, 32'd0);
        chk("lit_rst_data", write_data, 32'd0);
        chk("lit_rst_count", {30'd0, fifo_count}, 32'd0);
        chk("lit_rst_ready", {31'd0, ll_ready}, 32'd0);
        chk("lit_rst_pend", {30'd0, rs1_pending, rs2_pending}, 32'd0);
        tick(); tick();
        idle(); reset = 1'b1; #1;
        chk("lit_release_ready", {31'd0, ll_ready}, 32'd1);
        tick();
        chk("lit_release_no_write", {31'd0, reg_write_enable}, 32'd0);

        // Mixed traffic; a stalled ALU result is held as upstream would
        for (int k = 0; k < 120; k++) begin
            if (!m_last_stall) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            ll_valid    = ($urandom_range(0, 1) != 0);
            ll_rd       = 5'($urandom_range(0, 31));
            ll_data     = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            query_rs1   = 5'($urandom_range(0, 31));
            query_rs2   = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
